// File: rtl/move_executor.sv
// Debounces the network's raw move decision and applies accepted moves to a
// lane position on each game tick, with wall detection and a step counter.
module move_executor #(
    parameter int STABLE_CYCLES = 4,
    parameter int POS_MAX       = 7,
    parameter int POS_INIT      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  move,
    input  logic        tick,
    output logic [3:0]  pos,
    output logic [1:0]  stable_move,
    output logic        step_valid,
    output logic        bump,
    output logic        running,
    output logic [15:0] step_count
);

    typedef enum logic {SETTLE, RUN} state_t;

    localparam logic [3:0] STABLE_L   = 4'(STABLE_CYCLES);
    localparam logic [3:0] POS_MAX_L  = 4'(POS_MAX);
    localparam logic [3:0] POS_INIT_L = 4'(POS_INIT);

    state_t      state, state_nxt;
    logic [1:0]  cand;
    logic [3:0]  cnt;
    logic        accept;
    logic        apply;
    logic        blocked;
    logic [3:0]  pos_nxt;

    // Returns {blocked, next position}; a wall-blocked step keeps the position.
    function automatic logic [4:0] step_pos(input logic [1:0] dir, input logic [3:0] p);
        logic [4:0] r;
        r = {1'b0, p};
        case (dir)
            2'd0: r = (p == 4'd0)      ? {1'b1, p} : {1'b0, p - 4'd1};
            2'd2: r = (p == POS_MAX_L) ? {1'b1, p} : {1'b0, p + 4'd1};
            default: r = {1'b0, p};
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = (cnt == STABLE_L) && (cand != 2'd3);
        apply     = (state == RUN) && tick;
        running   = (state == RUN);
        {blocked, pos_nxt} = step_pos(stable_move, pos);
        if (state == SETTLE && accept) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SETTLE;
            cand        <= 2'd1;
            cnt         <= 4'd0;
            stable_move <= 2'd1;
            pos         <= POS_INIT_L;
            step_valid  <= 1'b0;
            bump        <= 1'b0;
            step_count  <= 16'd0;
        end else begin
            state <= state_nxt;
            cand  <= move;
            if (move != cand || cand == 2'd3) begin
                cnt <= 4'd1;
            end else if (cnt < STABLE_L) begin
                cnt <= cnt + 4'd1;
            end
            // The step below reads stable_move before this edge updates it.
            if (accept) begin
                stable_move <= cand;
            end
            step_valid <= apply;
            bump       <= apply && blocked;
            if (apply) begin
                pos        <= pos_nxt;
                step_count <= step_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 The block SHALL expose parameter STABLE_CYCLES, default 4, the number of consecutive identical move samples needed to accept a decision (legal range 1..15).
REQ-002 The block SHALL expose parameter POS_MAX, default 7, the highest legal lane index (legal range 1..15).
REQ-003 The block SHALL expose parameter POS_INIT, default 3, the lane index loaded at reset (must be <= POS_MAX).
REQ-004 Port list: clk  in  1  single clock, all logic on rising edge.
REQ-005 Port list: rst  in  1  synchronous, active-high reset.
REQ-006 Port list: move  in  2  raw decision from the neural network (0 = left, 1 = stay, 2 = right, 3 = invalid).
REQ-007 Port list: tick  in  1  one-cycle game-step strobe.
REQ-008 Port list: pos  out  4  current lane index.
REQ-009 Port list: stable_move  out  2  last accepted decision.
REQ-010 Port list: step_valid  out  1  one-cycle pulse marking a game step that was applied.
REQ-011 Port list: bump  out  1  one-cycle pulse marking a left or right step blocked at a wall.
REQ-012 Port list: running  out  1  high once the first decision has been accepted.
REQ-013 Port list: step_count  out  16  number of applied game steps.

Function
REQ-014 Filter: the block SHALL register move into cand each cycle.
- Counter cnt (4 bit) resets to 1 when move != cand or cand == 3.
- Otherwise cnt increments, saturating at STABLE_CYCLES.
REQ-015 Accept: stable_move SHALL load cand on the cycle cnt reaches STABLE_CYCLES with cand != 3, and SHALL hold otherwise.
REQ-016 Invalid: move == 3 SHALL never be accepted, and stable_move SHALL keep its prior value.
REQ-017 Latency: a constant move SHALL appear on stable_move exactly STABLE_CYCLES+1 clocks after it first appears on the input.
REQ-018 FSM: the block SHALL have two states.
- SETTLE is the reset state; ticks are ignored, running = 0, pos is held.
- RUN is entered on the first accept; running = 1.
- There is no return to SETTLE except by rst.
REQ-019 Step: in RUN, a tick SHALL apply the stable_move value registered before that edge.
- 0: pos-1, saturating at 0.
- 1: hold.
- 2: pos+1, saturating at POS_MAX.
REQ-020 Simultaneous events: when an accept and a tick occur in the same cycle, the tick SHALL use the old stable_move, and the new value SHALL take effect from the next tick.
REQ-021 step_valid SHALL pulse in the cycle after each tick applied in RUN, aligned with the updated pos.
REQ-022 bump SHALL pulse together with step_valid when a step is blocked: left at pos 0, or right at POS_MAX.
REQ-023 step_count SHALL increment with each step_valid and SHALL wrap from 0xFFFF to 0.
REQ-024 The first accept SHALL transition SETTLE to RUN, and a tick in that same cycle SHALL be ignored.
REQ-025 Outputs step_valid and bump SHALL never stay high for two consecutive cycles unless ticks arrive on consecutive cycles.

Reset
REQ-026 Reset values:
- pos = POS_INIT, stable_move = 1, step_valid = 0, bump = 0, running = 0, step_count = 0.
- cand = 1, cnt = 0, FSM = SETTLE.
REQ-027 Reset mid-operation SHALL override all activity in the cycle it is sampled, discarding any tick, accept or partial filter count.

Verification
REQ-028 Settle: reset, move = 2 held, ticks every 3 cycles -> pos stays 3 until stable_move = 2 at cycle 5, running = 1, then pos 4, 5, 6, 7 on successive ticks.
REQ-029 Saturation: pos = 7, stable_move = 2, tick -> pos stays 7, step_valid = 1 and bump = 1 for one cycle; same check at pos 0 with stable_move = 0.
REQ-030 Glitch rejection: stable_move = 0; move sequence 2,2,2,0,2,2,2 -> stable_move stays 0; move = 3 held 10 cycles -> stable_move unchanged.
REQ-031 Collision: tick asserted on the same cycle stable_move changes 0 -> 2 with pos = 4 -> pos = 3 on that step, pos = 4 on the next tick.
REQ-032 Wrap and reset: force 65536 applied ticks -> step_count = 0; assert rst during a tick in RUN -> next cycle pos = 3, running = 0, step_valid = 0.
